exc_sequencer: RTL and testbench
================================

Name: exc_sequencer

Overview:
Exception/interrupt controller for the MIPS32 pipeline, placed between the MEM stage and the CP0 register file.
- Prioritises pending exceptions, interrupts and ERET.
- Sequences the required CP0 writes (EPC, Cause, Status) over CP0's single write port.
- Arbitrates that port against pipeline MTC0 writes.
- Stalls, then flushes and redirects the pipeline.

Parameters:
EXC_VECTOR, 32'h0000_0040, handler entry PC driven on new_pc for all exceptions/interrupts.
ADDR_STATUS, 5'd12, CP0 Status address.
ADDR_CAUSE, 5'd13, CP0 Cause address.
ADDR_EPC, 5'd14, CP0 EPC address.

Ports:
clk  in  1  clock.
rst  in  1  reset, synchronous, active-high.
mem_pc  in  32  PC of instruction in MEM.
mem_in_ds  in  1  MEM instruction is in a branch delay slot.
exc_sys  in  1  syscall.
exc_ri  in  1  reserved instruction.
exc_ov  in  1  arithmetic overflow.
exc_tr  in  1  trap.
eret  in  1  ERET in MEM.
cp0_status  in  32  current CP0 Status.
cp0_cause  in  32  current CP0 Cause.
cp0_epc  in  32  current CP0 EPC.
mtc0_req  in  1  pipeline MTC0 write request.
mtc0_addr  in  5  MTC0 target address.
mtc0_data  in  32  MTC0 data.
cp0_we  out  1  CP0 write enable.
cp0_waddr  out  5  CP0 write address.
cp0_wdata  out  32  CP0 write data.
stall  out  1  hold IF..MEM.
flush  out  1  flush all stages (one-cycle pulse).
new_pc  out  32  redirect target, valid while flush=1.

Behaviour:
- **Reset:** state=IDLE; cp0_we=0, cp0_waddr=0, cp0_wdata=0, flush=0, new_pc=0. stall=0 unless an event is accepted that same cycle.
- **Interrupt pending:** int_pend = status[0] & ~status[1] & |(cause[15:8] & status[15:8]).
- **Priority:** int_pend > exc_ri > exc_ov > exc_tr > exc_sys > eret.
- **ExcCode:** Int=0, RI=10, Ov=12, Tr=13, Sys=8.
- **Acceptance:** only in IDLE. Accepted event in cycle T is latched into registers: kind, excode, epc_val = mem_in_ds ? mem_pc-4 : mem_pc, bd = mem_in_ds, status/cause snapshot. Inputs in non-IDLE states are ignored.
- **stall:** (state != IDLE) | accept. Combinational, high from T.
- **Exception path (registered outputs):**
  - T+1 W_EPC: we=1, addr=ADDR_EPC, data=epc_val.
  - T+2 W_CAUSE: we=1, addr=ADDR_CAUSE, data={bd, cause_snap[30:7], excode, 2'b00}.
  - T+3 W_STATUS: we=1, addr=ADDR_STATUS, data=status_snap | 32'h2 (set EXL).
  - T+4 REDIRECT: we=0, flush=1, new_pc=EXC_VECTOR, stall=1.
  - T+5: IDLE.
- **ERET path:**
  - T+1 W_STATUS: data=status_snap & ~32'h2.
  - T+2 REDIRECT: flush=1, new_pc = EPC latched at T from cp0_epc.
  - T+3: IDLE.
- **MTC0 arbitration:** in IDLE with no accepted event, mtc0_req passes through combinationally: we=1, addr=mtc0_addr, data=mtc0_data. If an event is accepted in the same cycle, the MTC0 is dropped (we=0 at T); the instruction is flushed anyway. MTC0 is never granted in non-IDLE states.
- **Arithmetic:** epc_val subtraction is 32-bit, wrap-around allowed (mem_pc=0, ds=1 -> 32'hFFFF_FFFC).
- **Single-cycle outputs:** flush is exactly one cycle per event; cp0_we never high in REDIRECT.
- **Reset mid-sequence:** immediate IDLE, no further writes; already-completed writes are not undone.

Test Plan:
1. exc_sys, mem_pc=0x100, ds=0, cause=0, status=0x1000_0000 -> writes EPC=0x100 @T+1, Cause=0x0000_0020 @T+2, Status=0x1000_0002 @T+3; flush, new_pc=0x40 @T+4; stall T..T+4.
2. exc_ri, mem_pc=0x204, ds=1 -> EPC=0x200, Cause=0x8000_0028.
3. status=0x1000_0401, cause=0x400 (IP2), exc_ov=1 same cycle -> interrupt wins, Cause excode 0 (0x0000_0400). Repeat with status[1]=1 -> Ov taken, excode 12 (Cause 0x430).
4. exc_ov+exc_sys+mtc0_req(addr 11, 0x55) same cycle -> no write at T, Ov sequence follows. Alone in IDLE: mtc0 write same cycle, stall=0.
5. eret, cp0_epc=0x300, status=0x1000_0003 -> T+1 Status=0x1000_0001, T+2 flush, new_pc=0x300, T+3 IDLE.
6. rst at T+2 of an exception -> T+3 cp0_we=0, flush=0, state IDLE; new exc_sys after reset runs the full sequence.

Source files
------------

// File: rtl/exc_sequencer.sv
// Exception/interrupt sequencer between MEM and CP0: picks the winning event, walks the
// CP0 EPC/Cause/Status writes over the single write port, then flushes and redirects.
module exc_sequencer #(
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_0040,
  parameter logic [4:0]  ADDR_STATUS = 5'd12,
  parameter logic [4:0]  ADDR_CAUSE  = 5'd13,
  parameter logic [4:0]  ADDR_EPC    = 5'd14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_pc,
  input  logic        mem_in_ds,
  input  logic        exc_sys,
  input  logic        exc_ri,
  input  logic        exc_ov,
  input  logic        exc_tr,
  input  logic        eret,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic [31:0] cp0_epc,
  input  logic        mtc0_req,
  input  logic [4:0]  mtc0_addr,
  input  logic [31:0] mtc0_data,
  output logic        cp0_we,
  output logic [4:0]  cp0_waddr,
  output logic [31:0] cp0_wdata,
  output logic        stall,
  output logic        flush,
  output logic [31:0] new_pc
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_W_EPC    = 3'd1,
    S_W_CAUSE  = 3'd2,
    S_W_STATUS = 3'd3,
    S_REDIRECT = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        is_eret_q, is_eret_d;
  logic [4:0]  excode_q, excode_d;
  logic [31:0] epc_val_q, epc_val_d;
  logic        bd_q, bd_d;
  logic [31:0] status_snap_q, status_snap_d;
  logic [23:0] cause_snap_q, cause_snap_d;
  logic [31:0] epc_snap_q, epc_snap_d;

  logic        seq_we_q, seq_we_d;
  logic [4:0]  seq_waddr_q, seq_waddr_d;
  logic [31:0] seq_wdata_q, seq_wdata_d;
  logic        flush_q, flush_d;
  logic [31:0] new_pc_q, new_pc_d;

  logic        int_pend;
  logic        any_exc;
  logic        accept;
  logic        mtc0_grant;
  logic [4:0]  excode_sel;
  logic        unused_cause_bits;

  assign int_pend = cp0_status[0] & ~cp0_status[1] & (|(cp0_cause[15:8] & cp0_status[15:8]));
  assign any_exc  = int_pend | exc_ri | exc_ov | exc_tr | exc_sys;
  assign accept   = (state_q == S_IDLE) & (any_exc | eret);

  // Only Cause[30:7] survives into the rewritten Cause; the rest is regenerated.
  assign unused_cause_bits = ^{cp0_cause[31], cp0_cause[6:0]};

  always_comb begin
    if (int_pend) begin
      excode_sel = 5'd0;
    end else if (exc_ri) begin
      excode_sel = 5'd10;
    end else if (exc_ov) begin
      excode_sel = 5'd12;
    end else if (exc_tr) begin
      excode_sel = 5'd13;
    end else begin
      excode_sel = 5'd8;
    end
  end

  always_comb begin
    state_d       = state_q;
    is_eret_d     = is_eret_q;
    excode_d      = excode_q;
    epc_val_d     = epc_val_q;
    bd_d          = bd_q;
    status_snap_d = status_snap_q;
    cause_snap_d  = cause_snap_q;
    epc_snap_d    = epc_snap_q;
    seq_we_d      = 1'b0;
    seq_waddr_d   = 5'd0;
    seq_wdata_d   = 32'd0;
    flush_d       = 1'b0;
    new_pc_d      = 32'd0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          is_eret_d     = ~any_exc;
          excode_d      = excode_sel;
          epc_val_d     = mem_in_ds ? (mem_pc - 32'd4) : mem_pc;
          bd_d          = mem_in_ds;
          status_snap_d = cp0_status;
          cause_snap_d  = cp0_cause[30:7];
          epc_snap_d    = cp0_epc;
          state_d       = any_exc ? S_W_EPC : S_W_STATUS;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_W_EPC:    state_d = S_W_CAUSE;
      S_W_CAUSE:  state_d = S_W_STATUS;
      S_W_STATUS: state_d = S_REDIRECT;
      S_REDIRECT: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    case (state_d)
      S_W_EPC: begin
        seq_we_d    = 1'b1;
        seq_waddr_d = ADDR_EPC;
        seq_wdata_d = epc_val_d;
      end
      S_W_CAUSE: begin
        seq_we_d    = 1'b1;
        seq_waddr_d = ADDR_CAUSE;
        seq_wdata_d = {bd_d, cause_snap_d, excode_d, 2'b00};
      end
      S_W_STATUS: begin
        seq_we_d    = 1'b1;
        seq_waddr_d = ADDR_STATUS;
        seq_wdata_d = is_eret_d ? (status_snap_d & ~32'h0000_0002)
                                : (status_snap_d | 32'h0000_0002);
      end
      S_REDIRECT: begin
        flush_d  = 1'b1;
        new_pc_d = is_eret_d ? epc_snap_d : EXC_VECTOR;
      end
      default: begin
        seq_we_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      is_eret_q     <= 1'b0;
      excode_q      <= 5'd0;
      epc_val_q     <= 32'd0;
      bd_q          <= 1'b0;
      status_snap_q <= 32'd0;
      cause_snap_q  <= 24'd0;
      epc_snap_q    <= 32'd0;
      seq_we_q      <= 1'b0;
      seq_waddr_q   <= 5'd0;
      seq_wdata_q   <= 32'd0;
      flush_q       <= 1'b0;
      new_pc_q      <= 32'd0;
    end else begin
      state_q       <= state_d;
      is_eret_q     <= is_eret_d;
      excode_q      <= excode_d;
      epc_val_q     <= epc_val_d;
      bd_q          <= bd_d;
      status_snap_q <= status_snap_d;
      cause_snap_q  <= cause_snap_d;
      epc_snap_q    <= epc_snap_d;
      seq_we_q      <= seq_we_d;
      seq_waddr_q   <= seq_waddr_d;
      seq_wdata_q   <= seq_wdata_d;
      flush_q       <= flush_d;
      new_pc_q      <= new_pc_d;
    end
  end

  // MTC0 only gets the port in an idle cycle that does not start an event.
  assign mtc0_grant = (state_q == S_IDLE) & ~accept & mtc0_req;

  always_comb begin
    cp0_we = seq_we_q | mtc0_grant;
    if (seq_we_q) begin
      cp0_waddr = seq_waddr_q;
      cp0_wdata = seq_wdata_q;
    end else if (mtc0_grant) begin
      cp0_waddr = mtc0_addr;
      cp0_wdata = mtc0_data;
    end else begin
      cp0_waddr = 5'd0;
      cp0_wdata = 32'd0;
    end
  end

  assign stall  = (state_q != S_IDLE) | accept;
  assign flush  = flush_q;
  assign new_pc = new_pc_q;

endmodule

// File: tb/tb_exc_sequencer.sv
// Self-checking bench for exc_sequencer: directed plan cases plus random events,
// each compared cycle by cycle against a write-list reference model.
module tb_exc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_pc;
  logic        mem_in_ds;
  logic        exc_sys, exc_ri, exc_ov, exc_tr, eret;
  logic [31:0] cp0_status, cp0_cause, cp0_epc;
  logic        mtc0_req;
  logic [4:0]  mtc0_addr;
  logic [31:0] mtc0_data;
  logic        cp0_we;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic        stall, flush;
  logic [31:0] new_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exc_sequencer dut (
    .clk(clk), .rst(rst), .mem_pc(mem_pc), .mem_in_ds(mem_in_ds),
    .exc_sys(exc_sys), .exc_ri(exc_ri), .exc_ov(exc_ov), .exc_tr(exc_tr), .eret(eret),
    .cp0_status(cp0_status), .cp0_cause(cp0_cause), .cp0_epc(cp0_epc),
    .mtc0_req(mtc0_req), .mtc0_addr(mtc0_addr), .mtc0_data(mtc0_data),
    .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
    .stall(stall), .flush(flush), .new_pc(new_pc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    mem_pc = 32'd0; mem_in_ds = 1'b0;
    exc_sys = 1'b0; exc_ri = 1'b0; exc_ov = 1'b0; exc_tr = 1'b0; eret = 1'b0;
    cp0_status = 32'd0; cp0_cause = 32'd0; cp0_epc = 32'd0;
    mtc0_req = 1'b0; mtc0_addr = 5'd0; mtc0_data = 32'd0;
  endtask

  // Inputs that must be ignored while a sequence is in flight.
  task automatic junk();
    mem_pc = $urandom; mem_in_ds = 1'($urandom);
    exc_sys = 1'($urandom); exc_ri = 1'($urandom); exc_ov = 1'($urandom);
    exc_tr = 1'($urandom); eret = 1'($urandom);
    cp0_status = $urandom; cp0_cause = $urandom; cp0_epc = $urandom;
    mtc0_req = 1'($urandom); mtc0_addr = 5'($urandom); mtc0_data = $urandom;
  endtask

  // Drive one candidate event in an idle cycle and check every following cycle.
  task automatic run_evt(input string name,
                         input bit sys, input bit ri, input bit ov, input bit tr, input bit er,
                         input logic [31:0] pc, input bit ds,
                         input logic [31:0] st, input logic [31:0] ca, input logic [31:0] ep,
                         input bit mreq, input logic [4:0] ma, input logic [31:0] md);
    bit          int_p, has_exc, acc;
    int          code, n;
    bit          ew[4];
    logic [4:0]  ea[4];
    logic [31:0] ed[4];
    bit          ef[4];
    logic [31:0] ep_pc;
    logic [31:0] epc_v;

    int_p   = st[0] && !st[1] && ((ca[15:8] & st[15:8]) != 8'd0);
    has_exc = int_p || ri || ov || tr || sys;
    acc     = has_exc || er;
    if (int_p)      code = 0;
    else if (ri)    code = 10;
    else if (ov)    code = 12;
    else if (tr)    code = 13;
    else            code = 8;
    epc_v = ds ? pc - 32'd4 : pc;
    n = 0;
    ep_pc = 32'd0;
    if (has_exc) begin
      n = 4;
      ew[0] = 1; ea[0] = 5'd14; ed[0] = epc_v;                                   ef[0] = 0;
      ew[1] = 1; ea[1] = 5'd13;
      ed[1] = ({31'd0, ds} << 31) | (ca & 32'h7FFF_FF80) | (32'(code) << 2);     ef[1] = 0;
      ew[2] = 1; ea[2] = 5'd12; ed[2] = st | 32'h0000_0002;                      ef[2] = 0;
      ew[3] = 0; ea[3] = 5'd0;  ed[3] = 32'd0;                                   ef[3] = 1;
      ep_pc = 32'h0000_0040;
    end else if (er) begin
      n = 2;
      ew[0] = 1; ea[0] = 5'd12; ed[0] = st & 32'hFFFF_FFFD; ef[0] = 0;
      ew[1] = 0; ea[1] = 5'd0;  ed[1] = 32'd0;              ef[1] = 1;
      ep_pc = ep;
    end

    step();
    mem_pc = pc; mem_in_ds = ds;
    exc_sys = sys; exc_ri = ri; exc_ov = ov; exc_tr = tr; eret = er;
    cp0_status = st; cp0_cause = ca; cp0_epc = ep;
    mtc0_req = mreq; mtc0_addr = ma; mtc0_data = md;
    #1;
    chk({name, ".T.stall"}, 32'(stall), 32'(acc));
    chk({name, ".T.we"}, 32'(cp0_we), 32'(!acc && mreq));
    chk({name, ".T.flush"}, 32'(flush), 32'd0);
    if (!acc && mreq) begin
      chk({name, ".T.mtc0_addr"}, 32'(cp0_waddr), 32'(ma));
      chk({name, ".T.mtc0_data"}, cp0_wdata, md);
    end

    for (int k = 0; k < n; k++) begin
      step();
      junk();
      #1;
      chk($sformatf("%s.T+%0d.stall", name, k + 1), 32'(stall), 32'd1);
      chk($sformatf("%s.T+%0d.we", name, k + 1), 32'(cp0_we), 32'(ew[k]));
      chk($sformatf("%s.T+%0d.flush", name, k + 1), 32'(flush), 32'(ef[k]));
      if (ew[k]) begin
        chk($sformatf("%s.T+%0d.addr", name, k + 1), 32'(cp0_waddr), 32'(ea[k]));
        chk($sformatf("%s.T+%0d.data", name, k + 1), cp0_wdata, ed[k]);
      end
      if (ef[k]) chk($sformatf("%s.T+%0d.new_pc", name, k + 1), new_pc, ep_pc);
    end

    step();
    quiet();
    #1;
    chk({name, ".end.stall"}, 32'(stall), 32'd0);
    chk({name, ".end.we"}, 32'(cp0_we), 32'd0);
    chk({name, ".end.flush"}, 32'(flush), 32'd0);
  endtask

  initial begin
    quiet();
    rst = 1'b1;
    step();
    step();
    chk("reset.we", 32'(cp0_we), 32'd0);
    chk("reset.waddr", 32'(cp0_waddr), 32'd0);
    chk("reset.wdata", cp0_wdata, 32'd0);
    chk("reset.flush", 32'(flush), 32'd0);
    chk("reset.new_pc", new_pc, 32'd0);
    chk("reset.stall", 32'(stall), 32'd0);
    rst = 1'b0;

    run_evt("sys",      1,0,0,0,0, 32'h0000_0100, 0, 32'h1000_0000, 32'h0, 32'h0, 0, 5'd0, 32'h0);
    run_evt("ri_ds",    0,1,0,0,0, 32'h0000_0204, 1, 32'h1000_0000, 32'h0, 32'h0, 0, 5'd0, 32'h0);
    run_evt("int_ov",   0,0,1,0,0, 32'h0000_0300, 0, 32'h1000_0401, 32'h400, 32'h0, 0, 5'd0, 32'h0);
    run_evt("exl_ov",   0,0,1,0,0, 32'h0000_0300, 0, 32'h1000_0403, 32'h400, 32'h0, 0, 5'd0, 32'h0);
    run_evt("ov_mtc0",  1,0,1,0,0, 32'h0000_0400, 0, 32'h1000_0000, 32'h0, 32'h0, 1, 5'd11, 32'h55);
    run_evt("mtc0",     0,0,0,0,0, 32'h0000_0400, 0, 32'h1000_0000, 32'h0, 32'h0, 1, 5'd11, 32'h55);
    run_evt("eret",     0,0,0,0,1, 32'h0000_0500, 0, 32'h1000_0003, 32'h0, 32'h300, 0, 5'd0, 32'h0);
    run_evt("wrap",     1,0,0,0,0, 32'h0000_0000, 1, 32'h1000_0000, 32'h0, 32'h0, 0, 5'd0, 32'h0);
    run_evt("tr",       0,0,0,1,0, 32'h0000_0600, 0, 32'h1000_0000, 32'h7C, 32'h0, 0, 5'd0, 32'h0);
    run_evt("sys_eret", 1,0,0,0,1, 32'h0000_0700, 0, 32'h1000_0003, 32'h0, 32'h900, 0, 5'd0, 32'h0);

    // Reset while the Cause write is on the port.
    step();
    exc_sys = 1'b1; mem_pc = 32'h0000_0800; cp0_status = 32'h1000_0000;
    #1;
    chk("rstmid.T.stall", 32'(stall), 32'd1);
    step();
    quiet();
    #1;
    chk("rstmid.T+1.addr", 32'(cp0_waddr), 32'd14);
    step();
    rst = 1'b1;
    #1;
    chk("rstmid.T+2.we", 32'(cp0_we), 32'd1);
    chk("rstmid.T+2.addr", 32'(cp0_waddr), 32'd13);
    step();
    rst = 1'b0;
    #1;
    chk("rstmid.T+3.we", 32'(cp0_we), 32'd0);
    chk("rstmid.T+3.flush", 32'(flush), 32'd0);
    chk("rstmid.T+3.stall", 32'(stall), 32'd0);
    step();
    chk("rstmid.T+4.we", 32'(cp0_we), 32'd0);
    chk("rstmid.T+4.flush", 32'(flush), 32'd0);
    run_evt("after_rst", 1,0,0,0,0, 32'h0000_0900, 0, 32'h1000_0000, 32'h0, 32'h0, 0, 5'd0, 32'h0);

    for (int i = 0; i < 60; i++) begin
      run_evt($sformatf("rnd%0d", i),
              ($urandom_range(3) == 0), ($urandom_range(3) == 0), ($urandom_range(3) == 0),
              ($urandom_range(3) == 0), ($urandom_range(2) == 0),
              $urandom, 1'($urandom), $urandom, $urandom, $urandom,
              1'($urandom), 5'($urandom), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
